sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Shares the single-port external SRAM between instruction fetch (IF) and the MEM stage of the 16-bit pipeline.
//  Sequences the SRAM read and write strobes.
//  Returns fetched instructions and load data to their requesters.
//  Drives stall_if while a fetch is outstanding.
//  Sits between the IF/MEM stages and the board SRAM pins; replaces the combinational instruction ROM.
// PARAMETERS
//  ADDR_W    16        SRAM word address width
//  DATA_W    16        data/instruction width
//  RD_CYCLES 1         cycles ram_oe_n held low per read (>=1)
//  WR_CYCLES 1         cycles ram_we_n held low per write (>=1)
//  NOP_INST  16'h0800  instruction value presented on reset (pipeline NOP)
// PORTS
//  clk         in   1       system clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  if_req      in   1       fetch request; held with if_addr stable until if_ready
//  if_addr     in   ADDR_W  fetch address (PC)
//  if_inst     out  DATA_W  last fetched instruction, registered
//  if_ready    out  1       one-cycle pulse: if_inst valid, fetch done
//  stall_if    out  1       if_req & ~if_ready
//  mem_rd      in   1       load request; held until mem_ready
//  mem_wr      in   1       store request; held until mem_ready
//  mem_addr    in   ADDR_W  load/store address
//  mem_wdata   in   DATA_W  store data
//  mem_rdata   out  DATA_W  load data, registered
//  mem_ready   out  1       one-cycle pulse: load/store done
//  ram_addr    out  ADDR_W  SRAM address, registered
//  ram_data_o  out  DATA_W  SRAM write data
//  ram_data_i  in   DATA_W  SRAM read data
//  ram_data_oe out  1       1 = drive SRAM data bus (tristate enable, top level)
//  ram_ce_n    out  1       SRAM chip enable, active-low
//  ram_oe_n    out  1       SRAM output enable, active-low
//  ram_we_n    out  1       SRAM write enable, active-low
// BEHAVIOUR
//  Reset (async, immediate) applies to all registered outputs:
//   - state=IDLE; ram_ce_n/oe_n/we_n=1; ram_data_oe=0; ram_addr=0.
//   - if_inst=NOP_INST; mem_rdata=0; readies=0; last_mem=0.
//   - An in-flight access is abandoned; no ready is issued for it.
//  FSM states: IDLE, RD, WSETUP, WPULSE, WHOLD.
//  IDLE:
//   - No grant in a cycle where if_ready or mem_ready is 1; the requester is still presenting the old request.
//   - Otherwise: MEM pending (mem_rd|mem_wr) and (~if_req | ~last_mem) -> grant MEM.
//   - Else if_req -> grant IF. mem_rd&mem_wr together is treated as a write.
//   - On grant: latch addr, wdata, owner and op; set ram_addr; set last_mem = (owner==MEM).
//  RD:
//   - ce_n=0, oe_n=0 for RD_CYCLES cycles.
//   - ram_data_i is sampled on the last edge into if_inst or mem_rdata; then IDLE with the owner's ready=1.
//  WSETUP (1 cycle): ce_n=0, data_oe=1, we_n=1.
//  WPULSE: we_n=0 for WR_CYCLES cycles.
//  WHOLD (1 cycle): we_n=1, data still driven; then IDLE with mem_ready=1.
//  ram_data_oe is 1 only in WSETUP/WPULSE/WHOLD; never overlaps oe_n=0.
//  Latency from a grant edge: read = RD_CYCLES+1 cycles to ready; write = WR_CYCLES+3 cycles.
//  Addresses/data changing or requests dropping mid-access are ignored; the access completes and ready still pulses.
//  Fairness: with both requesters continuously requesting, grants alternate MEM, IF, MEM, ...
//  if_inst/mem_rdata hold their value between readies.
// STRUCTURE
//  Shared header define.v: ADDR/DATA widths, NOP_INST, state encodings, owner encoding (OWN_IF/OWN_MEM).
//  One sub-module: sram_seq (strobe sequencer: go/op/addr/wdata -> pins, done, rdata). It has no arbitration.
//  The grant logic and owner/fairness registers live in sram_arbiter.
// TESTING
//  1. Reset: assert rst in WPULSE -> same cycle we_n=1, data_oe=0, if_inst=0x0800, mem_ready never pulses.
//  2. Fetch: if_req=1, if_addr=0x0003, SRAM[3]=0xE14D -> grant T0, RD T1, if_ready=1 at T2, if_inst=0xE14D.
//     stall_if=1 during T0-T1.
//  3. Store: mem_wr, addr 0x8000, data 0x1234 -> we_n=0 exactly 1 cycle; data_oe=1 for 3 cycles; mem_ready at T4.
//     SRAM[0x8000]=0x1234.
//  4. Collision: if_req and mem_rd (addr 0x0010, SRAM=0xBEEF) in the same cycle -> MEM served first, mem_rdata=0xBEEF.
//     IF served next; stall_if=1 until if_ready.
//  5. Fairness: mem_rd and if_req held for 12 cycles -> grant owners MEM, IF, MEM, IF; no back-to-back MEM grants.
//  6. mem_rd=mem_wr=1, addr 0x0020, data 0x5A5A -> write occurs, SRAM[0x20]=0x5A5A, oe_n stays 1.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter shared types: bus widths, reset instruction,
// sequencer state encodings and requester owner codes.
package sram_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam data_t NOP_DEF = 16'h0800;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD     = 3'd1;
  localparam logic [2:0] ST_WSETUP = 3'd2;
  localparam logic [2:0] ST_WPULSE = 3'd3;
  localparam logic [2:0] ST_WHOLD  = 3'd4;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

endpackage

// File: rtl/sram_arbiter_if.sv
// Pipeline-side request/response bundle of the SRAM arbiter:
// IF fetch channel and MEM load/store channel.
interface sram_arbiter_if;
  import sram_arbiter_pkg::*;

  logic  if_req;
  addr_t if_addr;
  data_t if_inst;
  logic  if_ready;
  logic  stall_if;

  logic  mem_rd;
  logic  mem_wr;
  addr_t mem_addr;
  data_t mem_wdata;
  data_t mem_rdata;
  logic  mem_ready;

  modport master (
    output if_req, if_addr,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  if_inst, if_ready, stall_if,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  if_req, if_addr,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output if_inst, if_ready, stall_if,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/sram_arbiter_seq.sv
// SRAM strobe sequencer: one go pulse runs a full read or
// write cycle on the pins; o_done marks the final edge.
module sram_arbiter_seq
  import sram_arbiter_pkg::*;
#(
  parameter int RD_CYCLES = 1,
  parameter int WR_CYCLES = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_go,
  input  logic  i_wr,
  input  addr_t i_addr,
  input  data_t i_wdata,
  output logic  o_idle,
  output logic  o_done,
  output data_t o_rdata,
  output addr_t o_ram_addr,
  output data_t o_ram_data,
  input  data_t i_ram_data,
  output logic  o_ram_data_oe,
  output logic  o_ram_ce_n,
  output logic  o_ram_oe_n,
  output logic  o_ram_we_n
);

  localparam logic [7:0] RD_LAST = 8'(RD_CYCLES - 1);
  localparam logic [7:0] WR_LAST = 8'(WR_CYCLES - 1);

  logic [2:0] r_state;
  logic [2:0] w_nxt;
  logic [7:0] r_cnt;
  logic       w_last;
  addr_t      r_addr;
  data_t      r_wdata;
  logic       r_ce_n;
  logic       r_oe_n;
  logic       r_we_n;
  logic       r_data_oe;

  always_comb begin
    w_nxt  = r_state;
    w_last = 1'b0;
    unique case (r_state)
      ST_IDLE:
        if (i_go) w_nxt = i_wr ? ST_WSETUP : ST_RD;
      ST_RD:
        if (r_cnt == RD_LAST) begin
          w_nxt  = ST_IDLE;
          w_last = 1'b1;
        end
      ST_WSETUP:
        w_nxt = ST_WPULSE;
      ST_WPULSE:
        if (r_cnt == WR_LAST) w_nxt = ST_WHOLD;
      ST_WHOLD: begin
        w_nxt  = ST_IDLE;
        w_last = 1'b1;
      end
      default:
        w_nxt = ST_IDLE;
    endcase
  end

  // Pin strobes are registered from the next state so they
  // change cleanly on the same edge as the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_ce_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_data_oe <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state)
        r_cnt <= '0;
      else if (r_state == ST_RD || r_state == ST_WPULSE)
        r_cnt <= r_cnt + 8'd1;
      if (i_go && r_state == ST_IDLE) begin
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
      r_ce_n    <= (w_nxt == ST_IDLE);
      r_oe_n    <= (w_nxt != ST_RD);
      r_we_n    <= (w_nxt != ST_WPULSE);
      r_data_oe <= (w_nxt == ST_WSETUP) ||
                   (w_nxt == ST_WPULSE) ||
                   (w_nxt == ST_WHOLD);
    end
  end

  assign o_idle        = (r_state == ST_IDLE);
  assign o_done        = w_last;
  assign o_rdata       = i_ram_data;
  assign o_ram_addr    = r_addr;
  assign o_ram_data    = r_wdata;
  assign o_ram_data_oe = r_data_oe;
  assign o_ram_ce_n    = r_ce_n;
  assign o_ram_oe_n    = r_oe_n;
  assign o_ram_we_n    = r_we_n;

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between instruction fetch and
// the MEM stage, alternating grants when both contend.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int    RD_CYCLES = 1,
  parameter int    WR_CYCLES = 1,
  parameter data_t NOP_INST  = NOP_DEF
) (
  input  logic  clk,
  input  logic  rst,
  sram_arbiter_if.slave bus,
  output addr_t o_ram_addr,
  output data_t o_ram_data,
  input  data_t i_ram_data,
  output logic  o_ram_data_oe,
  output logic  o_ram_ce_n,
  output logic  o_ram_oe_n,
  output logic  o_ram_we_n
);

  logic  w_idle;
  logic  w_done;
  logic  w_free;
  logic  w_mem_pend;
  logic  w_gnt_mem;
  logic  w_gnt_if;
  logic  w_go;
  logic  w_wr;
  addr_t w_addr;
  data_t w_rdata;

  logic  r_owner;
  logic  r_wr;
  logic  r_last_mem;
  logic  r_if_ready;
  logic  r_mem_ready;
  data_t r_if_inst;
  data_t r_mem_rdata;

  // A ready cycle still shows the old request, so hold off.
  assign w_free     = w_idle & ~r_if_ready & ~r_mem_ready;
  assign w_mem_pend = bus.mem_rd | bus.mem_wr;
  assign w_gnt_mem  = w_free & w_mem_pend &
                      (~bus.if_req | ~r_last_mem);
  assign w_gnt_if   = w_free & bus.if_req & ~w_gnt_mem;
  assign w_go       = w_gnt_mem | w_gnt_if;
  assign w_wr       = w_gnt_mem & bus.mem_wr;
  assign w_addr     = w_gnt_mem ? bus.mem_addr : bus.if_addr;

  sram_arbiter_seq #(
    .RD_CYCLES (RD_CYCLES),
    .WR_CYCLES (WR_CYCLES)
  ) u_seq (
    .clk           (clk),
    .rst           (rst),
    .i_go          (w_go),
    .i_wr          (w_wr),
    .i_addr        (w_addr),
    .i_wdata       (bus.mem_wdata),
    .o_idle        (w_idle),
    .o_done        (w_done),
    .o_rdata       (w_rdata),
    .o_ram_addr    (o_ram_addr),
    .o_ram_data    (o_ram_data),
    .i_ram_data    (i_ram_data),
    .o_ram_data_oe (o_ram_data_oe),
    .o_ram_ce_n    (o_ram_ce_n),
    .o_ram_oe_n    (o_ram_oe_n),
    .o_ram_we_n    (o_ram_we_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner     <= OWN_IF;
      r_wr        <= 1'b0;
      r_last_mem  <= 1'b0;
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
      r_if_inst   <= NOP_INST;
      r_mem_rdata <= '0;
    end else begin
      r_if_ready  <= w_done & (r_owner == OWN_IF);
      r_mem_ready <= w_done & (r_owner == OWN_MEM);
      if (w_go) begin
        r_owner    <= w_gnt_mem ? OWN_MEM : OWN_IF;
        r_wr       <= w_wr;
        r_last_mem <= w_gnt_mem;
      end
      unique case (1'b1)
        w_done & ~r_wr & (r_owner == OWN_MEM):
          r_mem_rdata <= w_rdata;
        w_done & ~r_wr & (r_owner == OWN_IF):
          r_if_inst <= w_rdata;
        default: ;
      endcase
    end
  end

  assign bus.if_inst   = r_if_inst;
  assign bus.if_ready  = r_if_ready;
  assign bus.stall_if  = bus.if_req & ~r_if_ready;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.mem_ready = r_mem_ready;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural SRAM:
// directed fetch/load/store, collision, fairness and reset.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  typedef struct packed {
    logic  wr;
    data_t d;
  } mexp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if bus();

  addr_t ram_addr;
  data_t ram_do;
  data_t ram_di;
  logic  ram_doe;
  logic  ce_n;
  logic  oe_n;
  logic  we_n;

  sram_arbiter #(
    .RD_CYCLES (1),
    .WR_CYCLES (1),
    .NOP_INST  (16'h0800)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .o_ram_addr    (ram_addr),
    .o_ram_data    (ram_do),
    .i_ram_data    (ram_di),
    .o_ram_data_oe (ram_doe),
    .o_ram_ce_n    (ce_n),
    .o_ram_oe_n    (oe_n),
    .o_ram_we_n    (we_n)
  );

  logic [15:0] sram [65536];
  assign ram_di = (!ce_n && !oe_n) ? sram[ram_addr] : 16'h0000;

  int total = 0;
  int bad = 0;
  int we_lo = 0;
  int doe_hi = 0;
  int oe_lo = 0;
  int mr_cnt = 0;

  data_t exp_if[$];
  mexp_t exp_mem[$];
  logic  got_order[$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic miss(input string nm);
    total++;
    bad++;
    $display("FAIL %s got=none exp=event", nm);
  endtask

  always @(negedge clk) begin
    if (!ce_n && !we_n && ram_doe) sram[ram_addr] = ram_do;
    if (!we_n) we_lo++;
    if (ram_doe) doe_hi++;
    if (!oe_n) oe_lo++;
  end

  always @(posedge clk) begin
    #1;
    if (bus.if_ready) begin
      got_order.push_back(OWN_IF);
      if (exp_if.size() == 0) chk("if_ready_unexp", 1, 0);
      else chk("if_inst", bus.if_inst, exp_if.pop_front());
    end
    if (bus.mem_ready) begin
      mexp_t e;
      mr_cnt++;
      got_order.push_back(OWN_MEM);
      if (exp_mem.size() == 0) chk("mem_ready_unexp", 1, 0);
      else begin
        e = exp_mem.pop_front();
        if (!e.wr) chk("mem_rdata", bus.mem_rdata, e.d);
      end
    end
    chk("stall_if", bus.stall_if, bus.if_req & ~bus.if_ready);
    chk("oe_overlap", ram_doe & ~oe_n, 0);
  end

  task automatic fetch(input addr_t a, input data_t d,
                       input int lat);
    int n = 0;
    @(negedge clk);
    bus.if_req = 1'b1;
    bus.if_addr = a;
    exp_if.push_back(d);
    #1 chk("stall_t0", bus.stall_if, 1);
    do begin
      @(posedge clk);
      #1 n++;
    end while (!bus.if_ready && n < 40);
    if (!bus.if_ready) miss("if_timeout");
    if (lat >= 0) chk("if_latency", n, lat);
    @(negedge clk);
    bus.if_req = 1'b0;
  endtask

  task automatic mem_op(input logic rd, input logic wr,
                        input addr_t a, input data_t wd,
                        input data_t d, input int lat);
    int n = 0;
    mexp_t e;
    @(negedge clk);
    bus.mem_rd = rd;
    bus.mem_wr = wr;
    bus.mem_addr = a;
    bus.mem_wdata = wd;
    e.wr = wr;
    e.d = d;
    exp_mem.push_back(e);
    do begin
      @(posedge clk);
      #1 n++;
    end while (!bus.mem_ready && n < 40);
    if (!bus.mem_ready) miss("mem_timeout");
    if (lat >= 0) chk("mem_latency", n, lat);
    @(negedge clk);
    bus.mem_rd = 1'b0;
    bus.mem_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic fo [4];
    fo = '{OWN_MEM, OWN_IF, OWN_MEM, OWN_IF};
    bus.if_req = 0;
    bus.if_addr = '0;
    bus.mem_rd = 0;
    bus.mem_wr = 0;
    bus.mem_addr = '0;
    bus.mem_wdata = '0;
    sram[16'h0003] = 16'hE14D;
    sram[16'h0010] = 16'hBEEF;
    sram[16'h0020] = 16'h0000;
    sram[16'h8000] = 16'h0000;
    #2 rst = 1'b1;
    #1;
    chk("rst_if_inst", bus.if_inst, 16'h0800);
    chk("rst_mem_rdata", bus.mem_rdata, 0);
    chk("rst_readies", {bus.if_ready, bus.mem_ready}, 0);
    chk("rst_strobes", {ce_n, oe_n, we_n, ram_doe}, 4'b1110);
    chk("rst_ram_addr", ram_addr, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // store: 1-cycle we_n pulse, 3 cycles of bus drive
    we_lo = 0;
    doe_hi = 0;
    mem_op(0, 1, 16'h8000, 16'h1234, 16'h0, 4);
    chk("st_we_cycles", we_lo, 1);
    chk("st_doe_cycles", doe_hi, 3);
    chk("st_sram", sram[16'h8000], 16'h1234);

    fetch(16'h0003, 16'hE14D, 2);
    repeat (3) @(posedge clk);
    #1 chk("if_inst_hold", bus.if_inst, 16'hE14D);

    // simultaneous requests after an IF grant: MEM first
    got_order.delete();
    fork
      fetch(16'h0003, 16'hE14D, -1);
      mem_op(1, 0, 16'h0010, 16'h0, 16'hBEEF, 2);
    join
    repeat (2) @(posedge clk);
    chk("coll_count", got_order.size(), 2);
    if (got_order.size() >= 2) begin
      chk("coll_first", got_order[0], OWN_MEM);
      chk("coll_second", got_order[1], OWN_IF);
    end

    // both held 12 cycles -> MEM, IF, MEM, IF
    got_order.delete();
    @(negedge clk);
    bus.mem_rd = 1'b1;
    bus.mem_addr = 16'h0010;
    bus.if_req = 1'b1;
    bus.if_addr = 16'h0003;
    for (int i = 0; i < 2; i++) begin
      exp_mem.push_back('{1'b0, 16'hBEEF});
      exp_if.push_back(16'hE14D);
    end
    repeat (12) @(posedge clk);
    @(negedge clk);
    bus.mem_rd = 1'b0;
    bus.if_req = 1'b0;
    repeat (4) @(posedge clk);
    chk("fair_count", got_order.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got_order.size())
        chk($sformatf("fair_%0d", i), got_order[i], fo[i]);

    // rd and wr together behave as a write
    oe_lo = 0;
    mem_op(1, 1, 16'h0020, 16'h5A5A, 16'h0, 4);
    chk("rdwr_sram", sram[16'h0020], 16'h5A5A);
    chk("rdwr_oe_lo", oe_lo, 0);
    mem_op(1, 0, 16'h0020, 16'h0, 16'h5A5A, 2);

    // reset during the write pulse abandons the access
    n = mr_cnt;
    @(negedge clk);
    bus.mem_wr = 1'b1;
    bus.mem_addr = 16'h0040;
    bus.mem_wdata = 16'hFFFF;
    for (int i = 0; i < 20 && we_n; i++) @(negedge clk);
    chk("rst_mid_we_seen", we_n, 0);
    rst = 1'b1;
    #1;
    chk("rst_mid_we_n", we_n, 1);
    chk("rst_mid_doe", ram_doe, 0);
    chk("rst_mid_if_inst", bus.if_inst, 16'h0800);
    chk("rst_mid_ce_n", ce_n, 1);
    bus.mem_wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("rst_mid_no_ready", mr_cnt, n);

    fetch(16'h0003, 16'hE14D, 2);
    repeat (2) @(posedge clk);
    chk("queues_empty", exp_if.size() + exp_mem.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
